// File: rtl/ycr1_div_pkg.sv
// Shared types, parameter checks and helpers for the ycr1 parametrised divider.
package ycr1_div_pkg;

  typedef enum logic [2:0] {IDLE, PREP, COMP, FIX, DONE} div_state_e;

  localparam int unsigned DIV_MAX_XLEN = 64;

  function automatic bit div_params_ok(input int unsigned xlen, input int unsigned bpc);
    return (xlen >= 8) && (xlen <= DIV_MAX_XLEN) &&
           ((bpc == 1) || (bpc == 2) || (bpc == 4)) && ((xlen % bpc) == 0);
  endfunction

  // Leading zeros counted within the low w bits of v.
  function automatic int unsigned clz(input logic [DIV_MAX_XLEN-1:0] v, input int unsigned w);
    int unsigned n;
    logic        found;
    n     = 0;
    found = 1'b0;
    for (int i = DIV_MAX_XLEN - 1; i >= 0; i--) begin
      if (i < int'(w)) begin
        if (v[i]) found = 1'b1;
        else if (!found) n = n + 1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/ycr1_div_step.sv
// One combinational restoring step: subtract divisor<<pos from the partial remainder if it fits.
module ycr1_div_step #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned PW   = $clog2(XLEN)
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] div_i,
  input  logic [PW-1:0]   pos_i,
  output logic [XLEN-1:0] rem_o,
  output logic            qbit_o
);

  logic [2*XLEN-1:0] shifted;
  logic [XLEN:0]     diff;
  logic              lost;

  // Divisor bits pushed above XLEN mean the shifted divisor cannot fit.
  assign shifted = {{XLEN{1'b0}}, div_i} << pos_i;
  assign lost    = |shifted[2*XLEN-1:XLEN];
  assign diff    = {1'b0, rem_i} - {1'b0, shifted[XLEN-1:0]};
  assign qbit_o  = !lost && !diff[XLEN];
  assign rem_o   = qbit_o ? diff[XLEN-1:0] : rem_i;

endmodule

// File: rtl/ycr1_pipe_div_param.sv
// Iterative restoring divider for the EXE stage, BPC quotient bits per cycle, valid/ready handshakes.
module ycr1_pipe_div_param
  import ycr1_div_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned BPC       = 2,
  parameter int unsigned EARLY_OUT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_signed_i,
  input  logic [XLEN-1:0] req_dividend_i,
  input  logic [XLEN-1:0] req_divisor_i,
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output logic [XLEN-1:0] resp_quotient_o,
  output logic [XLEN-1:0] resp_remainder_o,
  output logic            resp_div0_o,
  output logic            resp_ovf_o,
  output logic            busy_o
);

  localparam int unsigned N  = XLEN / BPC;
  localparam int unsigned CW = $clog2(N + 1);
  localparam int unsigned PW = $clog2(XLEN);

  if (!div_params_ok(XLEN, BPC)) begin : g_bad_params
    $error("ycr1_pipe_div_param: unsupported XLEN/BPC combination");
  end

  div_state_e      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] q_q, q_d;
  logic [XLEN-1:0] r_q, r_d;
  logic            sgn_q, sgn_d;
  logic            neg_q_q, neg_q_d;
  logic            neg_r_q, neg_r_d;
  logic            div0_q, div0_d;
  logic            ovf_q, ovf_d;
  logic            valid_q, valid_d;
  logic            busy_q, busy_d;

  logic            sa, sb;
  logic [XLEN-1:0] abs_a, abs_b;
  logic [CW-1:0]   iter_cnt;
  logic [PW-1:0]   base_pos;
  logic [XLEN-1:0] rem_c [BPC+1];
  logic [BPC-1:0]  qbits;

  assign sa    = sgn_q & a_q[XLEN-1];
  assign sb    = sgn_q & b_q[XLEN-1];
  assign abs_a = sa ? -a_q : a_q;
  assign abs_b = sb ? -b_q : b_q;

  // Early-out skips the all-zero leading digit groups of |a|.
  always_comb begin
    iter_cnt = CW'(N);
    if (EARLY_OUT != 0)
      iter_cnt = CW'((XLEN - clz(DIV_MAX_XLEN'(abs_a), XLEN) + BPC - 1) / BPC);
  end

  // cnt_q counts remaining digit groups; the current group is cnt_q-1, MSB step first.
  always_comb base_pos = PW'((int'(cnt_q) - 1) * int'(BPC));

  assign rem_c[0] = r_q;

  for (genvar j = 0; j < BPC; j++) begin : g_step
    ycr1_div_step #(.XLEN(XLEN), .PW(PW)) u_step (
      .rem_i  (rem_c[j]),
      .div_i  (b_q),
      .pos_i  (base_pos + PW'(BPC - 1 - j)),
      .rem_o  (rem_c[j+1]),
      .qbit_o (qbits[BPC-1-j])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    q_d     = q_q;
    r_d     = r_q;
    sgn_d   = sgn_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    div0_d  = div0_q;
    ovf_d   = ovf_q;
    valid_d = valid_q;
    busy_d  = busy_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          state_d = PREP;
          a_d     = req_dividend_i;
          b_d     = req_divisor_i;
          sgn_d   = req_signed_i;
          div0_d  = 1'b0;
          ovf_d   = 1'b0;
          busy_d  = 1'b1;
        end
      end
      PREP: begin
        neg_q_d = sa ^ sb;
        neg_r_d = sa;
        if (b_q == '0) begin
          q_d     = '1;
          r_d     = a_q;
          div0_d  = 1'b1;
          valid_d = 1'b1;
          state_d = DONE;
        end else if (sgn_q && (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (&b_q)) begin
          q_d     = a_q;
          r_d     = '0;
          ovf_d   = 1'b1;
          valid_d = 1'b1;
          state_d = DONE;
        end else begin
          q_d     = '0;
          r_d     = abs_a;
          b_d     = abs_b;
          cnt_d   = iter_cnt;
          state_d = (iter_cnt == '0) ? FIX : COMP;
        end
      end
      COMP: begin
        q_d   = {q_q[XLEN-BPC-1:0], qbits};
        r_d   = rem_c[BPC];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = FIX;
      end
      FIX: begin
        q_d     = neg_q_q ? -q_q : q_q;
        r_d     = neg_r_q ? -r_q : r_q;
        valid_d = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (resp_ready_i) begin
          valid_d = 1'b0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A pipeline kill drops whatever is in flight, including a pending request.
    if (flush_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      valid_d = 1'b0;
      busy_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      q_q     <= '0;
      r_q     <= '0;
      sgn_q   <= 1'b0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      div0_q  <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      q_q     <= q_d;
      r_q     <= r_d;
      sgn_q   <= sgn_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
      div0_q  <= div0_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign req_ready_o      = (state_q == IDLE) && !flush_i;
  assign resp_valid_o     = valid_q;
  assign resp_quotient_o  = q_q;
  assign resp_remainder_o = r_q;
  assign resp_div0_o      = div0_q;
  assign resp_ovf_o       = ovf_q;
  assign busy_o           = busy_q;

endmodule

// File: tb/tb_ycr1_pipe_div_param.sv
// Directed and random checks of ycr1_pipe_div_param across BPC/EARLY_OUT variants sharing one stimulus.
module tb_ycr1_pipe_div_param;

  localparam int NI = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_signed = 1'b0;
  logic        resp_ready = 1'b1;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;

  logic        rdy [NI];
  logic        vld [NI];
  logic        d0o [NI];
  logic        ovo [NI];
  logic        bsy [NI];
  logic [31:0] qo  [NI];
  logic [31:0] ro  [NI];

  int          total = 0;
  int          bad   = 0;

  bit          got     [NI];
  int          got_lat [NI];
  logic [31:0] got_q   [NI];
  logic [31:0] got_r   [NI];
  logic        got_d0  [NI];
  logic        got_ov  [NI];

  typedef struct packed {
    logic        sgn;
    logic [31:0] a, b, q, r;
    logic        d0, ov;
    logic [31:0] lats;   // expected latency per instance, one byte each, instance 0 in the top byte
  } vec_t;

  always #5 clk = ~clk;

  // u0: BPC2 no early-out, u1: BPC2 early-out, u2: BPC1 early-out, u3: BPC4 no early-out
  ycr1_pipe_div_param #(.XLEN(32), .BPC(2), .EARLY_OUT(0)) u0 (
    .clk(clk), .rst(rst), .flush_i(flush), .req_valid_i(req_valid), .req_ready_o(rdy[0]),
    .req_signed_i(req_signed), .req_dividend_i(a_in), .req_divisor_i(b_in),
    .resp_valid_o(vld[0]), .resp_ready_i(resp_ready), .resp_quotient_o(qo[0]),
    .resp_remainder_o(ro[0]), .resp_div0_o(d0o[0]), .resp_ovf_o(ovo[0]), .busy_o(bsy[0]));
  ycr1_pipe_div_param #(.XLEN(32), .BPC(2), .EARLY_OUT(1)) u1 (
    .clk(clk), .rst(rst), .flush_i(flush), .req_valid_i(req_valid), .req_ready_o(rdy[1]),
    .req_signed_i(req_signed), .req_dividend_i(a_in), .req_divisor_i(b_in),
    .resp_valid_o(vld[1]), .resp_ready_i(resp_ready), .resp_quotient_o(qo[1]),
    .resp_remainder_o(ro[1]), .resp_div0_o(d0o[1]), .resp_ovf_o(ovo[1]), .busy_o(bsy[1]));
  ycr1_pipe_div_param #(.XLEN(32), .BPC(1), .EARLY_OUT(1)) u2 (
    .clk(clk), .rst(rst), .flush_i(flush), .req_valid_i(req_valid), .req_ready_o(rdy[2]),
    .req_signed_i(req_signed), .req_dividend_i(a_in), .req_divisor_i(b_in),
    .resp_valid_o(vld[2]), .resp_ready_i(resp_ready), .resp_quotient_o(qo[2]),
    .resp_remainder_o(ro[2]), .resp_div0_o(d0o[2]), .resp_ovf_o(ovo[2]), .busy_o(bsy[2]));
  ycr1_pipe_div_param #(.XLEN(32), .BPC(4), .EARLY_OUT(0)) u3 (
    .clk(clk), .rst(rst), .flush_i(flush), .req_valid_i(req_valid), .req_ready_o(rdy[3]),
    .req_signed_i(req_signed), .req_dividend_i(a_in), .req_divisor_i(b_in),
    .resp_valid_o(vld[3]), .resp_ready_i(resp_ready), .resp_quotient_o(qo[3]),
    .resp_remainder_o(ro[3]), .resp_div0_o(d0o[3]), .resp_ovf_o(ovo[3]), .busy_o(bsy[3]));

  // RISC-V reference semantics using the simulator's own arithmetic.
  function automatic void ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic d0, output logic ov);
    d0 = (b == 32'd0);
    ov = sgn && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    if (d0) begin
      q = 32'hFFFF_FFFF; r = a;
    end else if (ov) begin
      q = a; r = 32'd0;
    end else if (sgn) begin
      q = 32'($signed(a) / $signed(b));
      r = 32'($signed(a) % $signed(b));
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  task automatic wait_idle();
    bit all_rdy;
    for (int c = 0; c < 100; c++) begin
      all_rdy = 1'b1;
      for (int i = 0; i < NI; i++) if (!rdy[i]) all_rdy = 1'b0;
      if (all_rdy) return;
      @(posedge clk); #1;
    end
    total++; bad++;
    $display("FAIL wait_idle: instances never returned to idle within 100 cycles");
  endtask

  // Issue one request with resp_ready high and capture each instance's response and latency.
  task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    bit all_got;
    wait_idle();
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_signed = sgn;
    a_in       = a;
    b_in       = b;
    for (int i = 0; i < NI; i++) got[i] = 1'b0;
    @(posedge clk); #1;
    req_valid  = 1'b0;
    req_signed = ~sgn;
    a_in       = $urandom;
    b_in       = $urandom;
    for (int cyc = 1; cyc <= 80; cyc++) begin
      all_got = 1'b1;
      for (int i = 0; i < NI; i++) begin
        if (!got[i] && vld[i]) begin
          got[i] = 1'b1; got_lat[i] = cyc;
          got_q[i] = qo[i]; got_r[i] = ro[i]; got_d0[i] = d0o[i]; got_ov[i] = ovo[i];
        end
        if (!got[i]) all_got = 1'b0;
      end
      if (all_got) break;
      @(posedge clk); #1;
    end
    for (int i = 0; i < NI; i++) begin
      if (!got[i]) begin
        total++; bad++;
        $display("FAIL timeout u%0d: no response for %h/%h within 80 cycles", i, a, b);
        got_lat[i] = -1;
      end
    end
  endtask

  task automatic test_reset();
    #1;
    for (int i = 0; i < NI; i++) begin
      total++;
      if ({vld[i], d0o[i], ovo[i], bsy[i], rdy[i], qo[i], ro[i]} !== {5'b00001, 64'd0}) begin
        bad++;
        $display("FAIL reset u%0d: got v=%b d0=%b ov=%b busy=%b rdy=%b q=%h r=%h, want 0 0 0 0 1 0 0",
                 i, vld[i], d0o[i], ovo[i], bsy[i], rdy[i], qo[i], ro[i]);
      end
    end
    #11 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_divide();
    vec_t tbl [12];
    tbl[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 1'b0, {8'd19, 8'd7,  8'd10, 8'd11}};
    tbl[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 1'b0, {8'd19, 8'd5,  8'd6,  8'd11}};
    tbl[2]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0, 1'b0, {8'd19, 8'd5,  8'd6,  8'd11}};
    tbl[3]  = '{1'b0, 32'h1234,       32'd0,          32'hFFFF_FFFF,  32'h1234,       1'b1, 1'b0, {8'd2,  8'd2,  8'd2,  8'd2}};
    tbl[4]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, 1'b1, {8'd2,  8'd2,  8'd2,  8'd2}};
    tbl[5]  = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0, 1'b0, {8'd19, 8'd19, 8'd35, 8'd11}};
    tbl[6]  = '{1'b0, 32'hFFFF_FFFF,  32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  1'b0, 1'b0, {8'd19, 8'd19, 8'd35, 8'd11}};
    tbl[7]  = '{1'b0, 32'd5,          32'd3,          32'd1,          32'd2,          1'b0, 1'b0, {8'd19, 8'd5,  8'd6,  8'd11}};
    tbl[8]  = '{1'b0, 32'd0,          32'd9,          32'd0,          32'd0,          1'b0, 1'b0, {8'd19, 8'd3,  8'd3,  8'd11}};
    tbl[9]  = '{1'b1, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFF9,  1'b1, 1'b0, {8'd2,  8'd2,  8'd2,  8'd2}};
    tbl[10] = '{1'b1, 32'h8000_0000,  32'd2,          32'hC000_0000,  32'd0,          1'b0, 1'b0, {8'd19, 8'd19, 8'd35, 8'd11}};
    tbl[11] = '{1'b0, 32'd3,          32'd10,         32'd0,          32'd3,          1'b0, 1'b0, {8'd19, 8'd4,  8'd5,  8'd11}};
    for (int v = 0; v < 12; v++) begin
      run_op(tbl[v].sgn, tbl[v].a, tbl[v].b);
      for (int i = 0; i < NI; i++) begin
        total++;
        if ({got_q[i], got_r[i], got_d0[i], got_ov[i]} !== {tbl[v].q, tbl[v].r, tbl[v].d0, tbl[v].ov}) begin
          bad++;
          $display("FAIL divide v%0d u%0d: got q=%h r=%h d0=%b ov=%b, want q=%h r=%h d0=%b ov=%b",
                   v, i, got_q[i], got_r[i], got_d0[i], got_ov[i], tbl[v].q, tbl[v].r, tbl[v].d0, tbl[v].ov);
        end
        total++;
        if (got_lat[i] != int'(tbl[v].lats[8*(3-i) +: 8])) begin
          bad++;
          $display("FAIL latency v%0d u%0d: got %0d, want %0d", v, i, got_lat[i], tbl[v].lats[8*(3-i) +: 8]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit seen;
    wait_idle();
    resp_ready = 1'b0;
    req_valid  = 1'b1; req_signed = 1'b0; a_in = 32'd100; b_in = 32'd7;
    @(posedge clk); #1;
    req_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      if (vld[0]) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    total++;
    if (!seen) begin bad++; $display("FAIL backpressure_start: got no response, want one within 40 cycles"); end
    req_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      total++;
      if ({vld[0], bsy[0], rdy[0], qo[0], ro[0], d0o[0], ovo[0]} !== {3'b110, 32'd14, 32'd2, 2'b00}) begin
        bad++;
        $display("FAIL hold%0d: got v=%b busy=%b rdy=%b q=%h r=%h d0=%b ov=%b, want 1 1 0 e 2 0 0",
                 k, vld[0], bsy[0], rdy[0], qo[0], ro[0], d0o[0], ovo[0]);
      end
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({vld[0], bsy[0], rdy[0]} !== 3'b001) begin
      bad++;
      $display("FAIL release: got v=%b busy=%b rdy=%b, want 0 0 1", vld[0], bsy[0], rdy[0]);
    end
  endtask

  task automatic test_flush();
    int vcount;
    wait_idle();
    resp_ready = 1'b1;
    req_valid  = 1'b1; req_signed = 1'b0; a_in = 32'hFFFF_FFFF; b_in = 32'd3;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    flush = 1'b1; req_valid = 1'b1;
    total++;
    if ({bsy[0], rdy[0], vld[0]} !== 3'b100) begin
      bad++;
      $display("FAIL flush_pre: got busy=%b rdy=%b v=%b, want 1 0 0", bsy[0], rdy[0], vld[0]);
    end
    @(posedge clk); #1;
    for (int i = 0; i < NI; i++) begin
      total++;
      if ({bsy[i], vld[i], rdy[i]} !== 3'b000) begin
        bad++;
        $display("FAIL flush_idle u%0d: got busy=%b v=%b rdy=%b, want 0 0 0", i, bsy[i], vld[i], rdy[i]);
      end
    end
    @(posedge clk); #1;
    total++;
    if (bsy[0] !== 1'b0) begin bad++; $display("FAIL flush_no_accept: got busy=%b, want 0", bsy[0]); end
    flush = 1'b0; req_valid = 1'b0;
    vcount = 0;
    repeat (40) begin
      @(posedge clk); #1;
      for (int i = 0; i < NI; i++) if (vld[i] || bsy[i]) vcount++;
    end
    total++;
    if (vcount != 0) begin bad++; $display("FAIL flush_quiet: got %0d valid/busy samples, want 0", vcount); end
    run_op(1'b0, 32'd1, 32'd1);
    for (int i = 0; i < NI; i++) begin
      total++;
      if ({got_q[i], got_r[i]} !== {32'd1, 32'd0}) begin
        bad++;
        $display("FAIL after_flush u%0d: got q=%h r=%h, want q=1 r=0", i, got_q[i], got_r[i]);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    wait_idle();
    req_valid = 1'b1; req_signed = 1'b0; a_in = 32'hFFFF_FFFF; b_in = 32'd3;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) begin
      total++;
      if ({vld[i], d0o[i], ovo[i], bsy[i], rdy[i], qo[i], ro[i]} !== {5'b00001, 64'd0}) begin
        bad++;
        $display("FAIL rst_mid u%0d: got v=%b d0=%b ov=%b busy=%b rdy=%b q=%h r=%h, want 0 0 0 0 1 0 0",
                 i, vld[i], d0o[i], ovo[i], bsy[i], rdy[i], qo[i], ro[i]);
      end
    end
    #2 rst = 1'b0;
    @(posedge clk); #1;
    repeat (3) begin @(posedge clk); #1; end
    total++;
    if ({vld[0], bsy[0]} !== 2'b00) begin
      bad++;
      $display("FAIL rst_quiet: got v=%b busy=%b, want 0 0", vld[0], bsy[0]);
    end
  endtask

  task automatic test_random();
    logic        sgn, ed0, eov;
    logic [31:0] a, b, eq, er;
    int          mode, lat0, lat3;
    for (int n = 0; n < 60; n++) begin
      sgn  = 1'($urandom_range(0, 1));
      a    = $urandom;
      b    = $urandom;
      mode = $urandom_range(0, 7);
      case (mode)
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: a = 32'($urandom_range(0, 255));
        4: b = b >> $urandom_range(0, 31);
        default: ;
      endcase
      ref_div(sgn, a, b, eq, er, ed0, eov);
      lat0 = (ed0 || eov) ? 2 : 19;
      lat3 = (ed0 || eov) ? 2 : 11;
      run_op(sgn, a, b);
      for (int i = 0; i < NI; i++) begin
        total++;
        if ({got_q[i], got_r[i], got_d0[i], got_ov[i]} !== {eq, er, ed0, eov}) begin
          bad++;
          $display("FAIL random%0d u%0d s=%b %h/%h: got q=%h r=%h d0=%b ov=%b, want q=%h r=%h d0=%b ov=%b",
                   n, i, sgn, a, b, got_q[i], got_r[i], got_d0[i], got_ov[i], eq, er, ed0, eov);
        end
      end
      total++;
      if ((got_lat[0] != lat0) || (got_lat[3] != lat3)) begin
        bad++;
        $display("FAIL random_lat%0d: got u0=%0d u3=%0d, want %0d %0d", n, got_lat[0], got_lat[3], lat0, lat3);
      end
    end
  endtask

  initial begin
    test_reset();
    test_divide();
    test_backpressure();
    test_flush();
    test_reset_mid_op();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
